// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_DRAIN} fetch_state_e;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with synchronous clear
module if_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch FSM, decode output register
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc,
  output logic        instr_valid
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   drain_addr_q, drain_addr_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          valid_q, valid_d;

  fetch_entry_t  fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_next;
  logic          req_raw, xfer, push, pop;

  if_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data ('{pc: pc_q, instr: imem_rdata}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Request is masked while reset is held so a reset mid-transfer drops it at once.
  always_comb begin
    pop = !stall && !redirect && !fifo_empty;
    unique case (state_q)
      S_FETCH: req_raw = (fifo_count < CW'(BUF_DEPTH)) || pop;
      S_DRAIN: req_raw = 1'b1;
      default: req_raw = 1'b0;
    endcase
    imem_req   = req_raw && !rst;
    imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    xfer       = imem_req && imem_ack;
    push       = xfer && (state_q == S_FETCH) && !redirect;
    count_next = fifo_count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if (redirect) begin
      pc_d = word_align(redirect_pc);
      if (imem_req && !imem_ack) begin
        state_d      = S_DRAIN;
        drain_addr_d = imem_addr;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH: if (push) begin
          pc_d = pc_q + PC_STEP;
          if (count_next == CW'(BUF_DEPTH)) state_d = S_FULL;
        end
        S_FULL:  if (pop) state_d = S_FETCH;
        S_DRAIN: if (xfer) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    instr_d    = instr_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    if (redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instr_d    = fifo_head.instr;
        fetch_pc_d = fifo_head.pc;
        valid_d    = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      fetch_pc_q   <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      fetch_pc_q   <= fetch_pc_d;
      valid_q      <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit: vector tables, corner sequences, random run
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] fetch_pc;
  logic        instr_valid;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .fetch_pc    (fetch_pc),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        ak;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc, input logic ak,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.st = st; v.rd = rd; v.rpc = rpc; v.ak = ak;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Called just after a falling edge: drive, check request side, clock, check decode side.
  task automatic run_vec(input vec_t v, input string tag);
    stall = v.st; redirect = v.rd; redirect_pc = v.rpc; imem_ack = v.ak;
    imem_rdata = mem_fn(imem_addr);
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(v.e_req));
    chk({tag, ".addr"}, imem_addr, v.e_addr);
    @(posedge clk); @(negedge clk);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v.e_valid));
    chk({tag, ".pc"}, fetch_pc, v.e_pc);
    chk({tag, ".instr"}, instr, v.e_valid ? mem_fn(v.e_pc) : NOP);
  endtask

  vec_t tab_a[13];

  initial begin
    logic [31:0] exp_next, pre_addr, pre_instr, pre_pc, last_addr;
    logic        pre_req, pre_valid, last_req, last_ack, st, rd, ak;
    logic [31:0] rpc;
    int          pops;

    tab_a[0]  = mk(0, 0, 0, 1, 1, 32'd0,  0, 32'd0);
    tab_a[1]  = mk(0, 0, 0, 1, 1, 32'd4,  1, 32'd0);
    tab_a[2]  = mk(0, 0, 0, 1, 1, 32'd8,  1, 32'd4);
    tab_a[3]  = mk(0, 0, 0, 1, 1, 32'd12, 1, 32'd8);
    tab_a[4]  = mk(1, 0, 0, 1, 1, 32'd16, 1, 32'd8);
    tab_a[5]  = mk(1, 0, 0, 1, 0, 32'd20, 1, 32'd8);
    tab_a[6]  = mk(1, 0, 0, 1, 0, 32'd20, 1, 32'd8);
    tab_a[7]  = mk(1, 0, 0, 1, 0, 32'd20, 1, 32'd8);
    tab_a[8]  = mk(1, 0, 0, 1, 0, 32'd20, 1, 32'd8);
    tab_a[9]  = mk(0, 0, 0, 1, 0, 32'd20, 1, 32'd12);
    tab_a[10] = mk(0, 0, 0, 1, 1, 32'd20, 1, 32'd16);
    tab_a[11] = mk(0, 0, 0, 1, 1, 32'd24, 1, 32'd20);
    tab_a[12] = mk(0, 0, 0, 1, 1, 32'd28, 1, 32'd24);

    @(negedge clk);
    chk("rst.req", 32'(imem_req), 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.instr", instr, NOP);
    chk("rst.pc", fetch_pc, 32'd0);

    do_reset();
    for (int i = 0; i < 13; i++) run_vec(tab_a[i], $sformatf("stream%0d", i));

    do_reset();
    run_vec(mk(0, 0, 0,        0, 1, 32'h0,  0, 32'h0),  "drain0");
    run_vec(mk(0, 1, 32'h43,   0, 1, 32'h0,  0, 32'h0),  "drain1");
    run_vec(mk(0, 0, 0,        1, 1, 32'h0,  0, 32'h0),  "drain2");
    run_vec(mk(0, 0, 0,        1, 1, 32'h40, 0, 32'h0),  "drain3");
    run_vec(mk(0, 0, 0,        0, 1, 32'h44, 1, 32'h40), "drain4");

    do_reset();
    run_vec(mk(0, 0, 0,        1, 1, 32'h0,  0, 32'h0),  "rdack0");
    run_vec(mk(0, 0, 0,        0, 1, 32'h4,  1, 32'h0),  "rdack1");
    run_vec(mk(1, 1, 32'h40,   1, 1, 32'h4,  0, 32'h0),  "rdack2");
    run_vec(mk(0, 0, 0,        1, 1, 32'h40, 0, 32'h0),  "rdack3");
    run_vec(mk(0, 0, 0,        0, 1, 32'h44, 1, 32'h40), "rdack4");

    do_reset();
    run_vec(mk(0, 1, 32'hFFFF_FFFF, 1, 1, 32'h0,         0, 32'h0),         "wrap0");
    run_vec(mk(0, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 32'h0),         "wrap1");
    run_vec(mk(0, 0, 0,             1, 1, 32'h0,         1, 32'hFFFF_FFFC), "wrap2");
    run_vec(mk(0, 0, 0,             0, 1, 32'h4,         1, 32'h0),         "wrap3");

    do_reset();
    run_vec(mk(0, 0, 0, 1, 1, 32'h0, 0, 32'h0), "mrst0");
    run_vec(mk(0, 0, 0, 0, 1, 32'h4, 1, 32'h0), "mrst1");
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = mem_fn(32'h4);
    #1;
    chk("mrst.req", 32'(imem_req), 32'd0);
    chk("mrst.addr", imem_addr, 32'd0);
    chk("mrst.valid", 32'(instr_valid), 32'd0);
    chk("mrst.instr", instr, NOP);
    chk("mrst.pc", fetch_pc, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 0, 0, 1, 1, 32'h0, 0, 32'h0), "mrst2");
    run_vec(mk(0, 0, 0, 0, 1, 32'h4, 1, 32'h0), "mrst3");
    run_vec(mk(0, 0, 0, 0, 1, 32'h4, 0, 32'h0), "mrst4");

    // Random run: decode must see consecutive PCs from the last redirect target, with matching data.
    do_reset();
    exp_next = 32'h0;
    pops = 0;
    last_req = 1'b0; last_ack = 1'b0; last_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(3) == 0);
      rd = ($urandom_range(19) == 0);
      ak = ($urandom_range(1) == 0);
      rpc = $urandom;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ak;
      imem_rdata = mem_fn(imem_addr);
      #1;
      pre_req = imem_req; pre_addr = imem_addr;
      pre_instr = instr; pre_pc = fetch_pc; pre_valid = instr_valid;
      if (last_req && !last_ack) begin
        chk("rnd.req_hold", 32'(pre_req), 32'd1);
        chk("rnd.addr_hold", pre_addr, last_addr);
      end
      if (pre_req) chk("rnd.align", 32'(pre_addr[1:0]), 32'd0);
      last_req = pre_req; last_ack = ak; last_addr = pre_addr;
      @(posedge clk); @(negedge clk);
      if (rd) begin
        chk("rnd.flush_valid", 32'(instr_valid), 32'd0);
        chk("rnd.flush_instr", instr, NOP);
        chk("rnd.flush_pc", fetch_pc, pre_pc);
        exp_next = rpc & 32'hFFFF_FFFC;
      end else if (st) begin
        chk("rnd.hold_valid", 32'(instr_valid), 32'(pre_valid));
        chk("rnd.hold_instr", instr, pre_instr);
        chk("rnd.hold_pc", fetch_pc, pre_pc);
      end else if (instr_valid) begin
        chk("rnd.order_pc", fetch_pc, exp_next);
        chk("rnd.data", instr, mem_fn(exp_next));
        exp_next = exp_next + 32'd4;
        pops++;
      end else begin
        chk("rnd.empty_instr", instr, NOP);
        chk("rnd.empty_pc", fetch_pc, pre_pc);
      end
    end
    chk("rnd.progress", 32'(pops >= 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
